ieee_sqrt_bcd_capture: RTL and testbench

Downstream display stage for the square-root op-amp loop. It watches the loop's IEEE-754 single-precision output on each sample strobe and waits until the value has settled. It then converts the settled value to 5 integer BCD digits and 2 truncated fraction BCD digits, with sign and exception flags. The result feeds the board's seven-segment/UART reporting path.

---
 rtl/ieee_conv_pkg.sv | 48 ++++
 rtl/bin16_to_bcd5_seq.sv | 45 ++++
 rtl/ieee_sqrt_bcd_capture.sv | 161 ++++++++++++++++
 tb/tb_ieee_sqrt_bcd_capture.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ieee_conv_pkg.sv
// Shared constants, FSM states and digit helpers for the
// IEEE-754 to BCD capture stage.
package ieee_conv_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_OVF  = 143;
  localparam int Q_FRAC   = 8;
  // exponent at which the 24-bit mantissa is already Q16.8
  localparam int Q_ALIGN  = EXP_BIAS + 23 - Q_FRAC;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    DABBLE,
    DONE
  } state_e;

  function automatic logic [19:0] dabble_step(
    input logic [19:0] bcd,
    input logic        b
  );
    logic [19:0] a;
    a = bcd;
    for (int k = 0; k < 5; k++) begin
      if (a[4*k +: 4] >= 4'd5)
        a[4*k +: 4] = a[4*k +: 4] + 4'd3;
    end
    return {a[18:0], b};
  endfunction

  // two truncated decimal digits of an 8-bit binary fraction
  function automatic logic [7:0] frac_digits(
    input logic [7:0] f
  );
    logic [14:0] p;
    logic [6:0]  g;
    logic [3:0]  t;
    p = (15'(f) << 6) + (15'(f) << 5) + (15'(f) << 2);
    g = p[14:8];
    t = 4'd0;
    if (g >= 7'd80) begin t = t + 4'd8; g = g - 7'd80; end
    if (g >= 7'd40) begin t = t + 4'd4; g = g - 7'd40; end
    if (g >= 7'd20) begin t = t + 4'd2; g = g - 7'd20; end
    if (g >= 7'd10) begin t = t + 4'd1; g = g - 7'd10; end
    return {t, g[3:0]};
  endfunction

endpackage

// File: rtl/bin16_to_bcd5_seq.sv
// Sequential double-dabble: 16-bit binary to 5 BCD digits,
// one bit per cycle, done pulses once the last bit is in.
module bin16_to_bcd5_seq
  import ieee_conv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic [19:0] bcd,
  output logic        done
);

  logic [14:0] sh;
  logic [3:0]  cnt;
  logic        run;

  // start already shifts in the MSB, so 15 more cycles remain
  always_ff @(posedge clk) begin
    if (reset) begin
      sh   <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      bcd  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh  <= bin[14:0];
        bcd <= dabble_step(20'd0, bin[15]);
        cnt <= 4'd1;
        run <= 1'b1;
      end else if (run) begin
        sh  <= {sh[13:0], 1'b0};
        bcd <= dabble_step(bcd, sh[14]);
        cnt <= cnt + 4'd1;
        if (cnt == 4'd15) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ieee_sqrt_bcd_capture.sv
// Waits for the sqrt loop output to settle, then converts it
// to 5.2 BCD digits with sign, overflow and NaN flags.
module ieee_sqrt_bcd_capture
  import ieee_conv_pkg::*;
#(
  parameter int SETTLE_CNT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic [31:0] ieee_in,
  output logic [19:0] bcd_int,
  output logic [7:0]  bcd_frac,
  output logic        neg,
  output logic        ovf,
  output logic        nan,
  output logic        valid,
  output logic        busy
);

  localparam int CW = $clog2(SETTLE_CNT + 1);
  localparam logic [CW-1:0] SAT = CW'(SETTLE_CNT);

  state_e state, state_n;

  logic [31:0]   prev;
  logic [31:0]   last_conv;
  logic [31:0]   work;
  logic [CW-1:0] cnt;

  logic          w_neg;
  logic          w_nan;
  logic          w_ovf;
  logic [7:0]    w_frac;

  logic          trig;
  logic          dab_start;
  logic          dab_done;
  logic [19:0]   dab_bcd;

  logic [7:0]    e;
  logic [23:0]   m;
  logic [7:0]    rsh;
  logic          a_nan;
  logic          a_ovf;
  logic [23:0]   q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
      cnt  <= '0;
    end else if (sample_en) begin
      if (ieee_in == prev) begin
        if (cnt != SAT)
          cnt <= cnt + CW'(1);
      end else begin
        prev <= ieee_in;
        cnt  <= CW'(1);
      end
    end
  end

  assign trig = (state == IDLE) && (cnt == SAT) &&
                (prev != last_conv);

  assign e     = work[30:23];
  assign m     = {1'b1, work[22:0]};
  assign a_nan = (e == 8'hFF) && (|work[22:0]);
  assign a_ovf = !a_nan && (e >= 8'(EXP_OVF));
  assign rsh   = 8'(Q_ALIGN) - e;

  // only right shifts remain once overflow is excluded
  always_comb begin
    q = '0;
    if (!a_nan && !a_ovf && e != 8'd0 && rsh < 8'd24)
      q = m >> rsh;
  end

  assign dab_start = (state == ALIGN);

  bin16_to_bcd5_seq u_dabble (
    .clk   (clk),
    .reset (reset),
    .start (dab_start),
    .bin   (q[23:8]),
    .bcd   (dab_bcd),
    .done  (dab_done)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (trig) state_n = ALIGN;
      ALIGN:  state_n = DABBLE;
      DABBLE: if (dab_done) state_n = DONE;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      work      <= '0;
      last_conv <= 32'hFFFF_FFFF;
      w_neg     <= 1'b0;
      w_nan     <= 1'b0;
      w_ovf     <= 1'b0;
      w_frac    <= '0;
    end else begin
      if (state == IDLE && trig) begin
        work      <= prev;
        last_conv <= prev;
      end
      if (state == ALIGN) begin
        w_neg  <= work[31];
        w_nan  <= a_nan;
        w_ovf  <= a_ovf;
        w_frac <= frac_digits(q[7:0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_int  <= '0;
      bcd_frac <= '0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
      nan      <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state == DABBLE && dab_done) begin
        valid <= 1'b1;
        neg   <= w_neg;
        ovf   <= w_ovf;
        nan   <= w_nan;
        if (w_ovf) begin
          bcd_int  <= 20'h99999;
          bcd_frac <= 8'h99;
        end else if (w_nan) begin
          bcd_int  <= '0;
          bcd_frac <= '0;
        end else begin
          bcd_int  <= dab_bcd;
          bcd_frac <= w_frac;
        end
      end
    end
  end

endmodule

// File: tb/tb_ieee_sqrt_bcd_capture.sv
// Scoreboard bench for ieee_sqrt_bcd_capture: expected digits
// are queued with each settled value and popped on valid.
module tb_ieee_sqrt_bcd_capture;

  typedef struct packed {
    logic [19:0] i;
    logic [7:0]  f;
    logic        n;
    logic        o;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_en = 1'b0;
  logic [31:0] ieee_in = '0;
  logic [19:0] bcd_int;
  logic [7:0]  bcd_frac;
  logic        neg;
  logic        ovf;
  logic        nan;
  logic        valid;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nvalid = 0;
  int valid_cyc = 0;
  int prev_valid_cyc = 0;
  int last_strobe_cyc = 0;
  exp_t q[$];

  ieee_sqrt_bcd_capture #(.SETTLE_CNT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .ieee_in   (ieee_in),
    .bcd_int   (bcd_int),
    .bcd_frac  (bcd_frac),
    .neg       (neg),
    .ovf       (ovf),
    .nan       (nan),
    .valid     (valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(
    input logic [19:0] i,
    input logic [7:0]  f,
    input logic        n,
    input logic        o,
    input logic        z
  );
    exp_t r;
    r.i = i; r.f = f; r.n = n; r.o = o; r.z = z;
    return r;
  endfunction

  // independent reference built from real arithmetic
  function automatic exp_t model(input logic [31:0] v);
    exp_t   r;
    int     e;
    real    a;
    longint fq, ip, fr, g;
    r = '0;
    r.n = v[31];
    e = int'(v[30:23]);
    if (e == 255 && v[22:0] != 0) begin
      r.z = 1'b1;
    end else if (e >= 143) begin
      r.o = 1'b1;
      r.i = 20'h99999;
      r.f = 8'h99;
    end else if (e != 0) begin
      a  = real'({1'b1, v[22:0]}) * (2.0 ** (e - 150));
      fq = longint'($floor(a * 256.0));
      ip = fq / 256;
      fr = fq % 256;
      g  = (fr * 100) / 256;
      for (int k = 0; k < 5; k++) begin
        r.i[4*k +: 4] = 4'(ip % 10);
        ip = ip / 10;
      end
      r.f = {4'(g / 10), 4'(g % 10)};
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (valid) begin
        exp_t x;
        nvalid++;
        prev_valid_cyc = valid_cyc;
        valid_cyc = cyc;
        check("sb_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          x = q.pop_front();
          check("bcd_int", 32'(bcd_int), 32'(x.i));
          check("bcd_frac", 32'(bcd_frac), 32'(x.f));
          check("neg", 32'(neg), 32'(x.n));
          check("ovf", 32'(ovf), 32'(x.o));
          check("nan", 32'(nan), 32'(x.z));
        end
      end
    end
  end

  task automatic strobe(
    input logic [31:0] v,
    input int          n,
    input int          gap
  );
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ieee_in = v;
      sample_en = 1'b1;
      @(posedge clk);
      #1;
      last_strobe_cyc = cyc;
      repeat (gap) begin
        @(negedge clk);
        sample_en = 1'b0;
      end
    end
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 3000; k++) begin
      if (q.size() == 0 && !busy) break;
      @(negedge clk);
    end
    check("idle_wait", 32'(k < 3000), 32'd1);
  endtask

  task automatic run_conv(input logic [31:0] v, input exp_t x);
    q.push_back(x);
    strobe(v, 8, 2);
    wait_idle();
  endtask

  logic [31:0] extra [6] = '{
    32'h42F6E979, 32'h477FFF00, 32'h3C23D70A,
    32'h00000001, 32'hFF800000, 32'hFFC00001
  };

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("rst_int", 32'(bcd_int), 32'd0);
    check("rst_frac", 32'(bcd_frac), 32'd0);
    check("rst_flags", 32'({neg, ovf, nan, valid, busy}), 32'd0);
    reset = 1'b0;

    run_conv(32'h40C00000, mk(20'h00006, 8'h00, 0, 0, 0));
    check("latency", 32'(valid_cyc - last_strobe_cyc), 32'd18);
    run_conv(32'h402DF854, mk(20'h00002, 8'h71, 0, 0, 0));
    run_conv(32'h3FC00000, mk(20'h00001, 8'h50, 0, 0, 0));

    base = nvalid;
    for (int r = 0; r < 2; r++) begin
      strobe(32'h40000000, 7, 2);
      strobe(32'h40400000, 7, 2);
    end
    strobe(32'h40000000, 7, 2);
    check("toggle_quiet", 32'(nvalid - base), 32'd0);
    run_conv(32'h40400000, mk(20'h00003, 8'h00, 0, 0, 0));
    strobe(32'h40400000, 100, 2);
    check("no_reconv", 32'(nvalid - base), 32'd1);

    run_conv(32'h47800000, mk(20'h99999, 8'h99, 0, 1, 0));
    run_conv(32'hC0000000, mk(20'h00002, 8'h00, 1, 0, 0));
    run_conv(32'h7FC00000, mk(20'h00000, 8'h00, 0, 0, 1));
    run_conv(32'h00000000, mk(20'h00000, 8'h00, 0, 0, 0));
    for (int k = 0; k < 6; k++)
      run_conv(extra[k], model(extra[k]));

    base = nvalid;
    strobe(32'h41200000, 8, 2);
    check("rst_mid_busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_idle", 32'(busy), 32'd0);
    check("rst_mid_int", 32'(bcd_int), 32'd0);
    check("rst_mid_flags", 32'({neg, ovf, nan}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_no_valid", 32'(nvalid - base), 32'd0);
    run_conv(32'h41200000, mk(20'h00010, 8'h00, 0, 0, 0));

    q.push_back(mk(20'h00005, 8'h00, 0, 0, 0));
    q.push_back(mk(20'h00007, 8'h00, 0, 0, 0));
    strobe(32'h40A00000, 8, 2);
    strobe(32'h40E00000, 8, 0);
    wait_idle();
    check("b2b_gap", 32'(valid_cyc - prev_valid_cyc), 32'd19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
